ahb_bus_arbiter: RTL and testbench

Multi-master AHB arbiter that shares one AHB bus between the DMAC master port and up to seven other bus masters. It samples each master's request and lock lines, tracks fixed-length bursts from the shared HTRANS/HBURST/HREADY bus, and hands grant over only at legal arbitration points. It drives one-hot HGRANT back to the masters, and drives HMASTER/HMASTLOCK to the address/data multiplexers and slaves.

---
 rtl/ahb_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: shares one AHB bus among NUM_MST masters, handing the grant over only at burst boundaries.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority with index 0 highest.
module ahb_bus_arbiter #(
    parameter int NUM_MST = 4,
    parameter int DEF_MST = 0
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NUM_MST-1:0] HBUSREQ,
    input  logic [NUM_MST-1:0] HLOCK,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HBURST,
    input  logic               HREADY,
    input  logic [1:0]         HRESP,
    output logic [NUM_MST-1:0] HGRANT,
    output logic [2:0]         HMASTER,
    output logic               HMASTLOCK
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'd0,
        RESP_ERROR = 2'd1,
        RESP_RETRY = 2'd2,
        RESP_SPLIT = 2'd3
    } hresp_e;

    localparam logic [2:0] DEF_IDX = 3'(DEF_MST);

    // Beats still to come after the NONSEQ beat of a burst of this type.
    function automatic logic [4:0] burst_remaining(input logic [2:0] burst);
        case (hburst_e'(burst))
            BURST_WRAP4,  BURST_INCR4:  return 5'd3;
            BURST_WRAP8,  BURST_INCR8:  return 5'd7;
            BURST_WRAP16, BURST_INCR16: return 5'd15;
            default:                    return 5'd0;
        endcase
    endfunction

    function automatic logic [NUM_MST-1:0] onehot(input logic [2:0] sel);
        logic [7:0] vec;
        vec = 8'd1 << sel;
        return vec[NUM_MST-1:0];
    endfunction

    logic [4:0] cnt;
    logic [4:0] next_cnt;
    logic [2:0] owner;
    logic [2:0] winner;
    logic [7:0] req_pad;
    logic [7:0] lock_pad;
    logic       hold;
    logic       arb_ok;

    // Widen to eight so a three-bit master index is always in range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        req_pad  = '0;
        lock_pad = '0;
        req_pad[NUM_MST-1:0]  = HBUSREQ;
        lock_pad[NUM_MST-1:0] = HLOCK;
    end

    always_comb begin
        next_cnt = cnt;
        if (HREADY) begin
            case (htrans_e'(HTRANS))
                TRANS_NONSEQ: next_cnt = burst_remaining(HBURST);
                TRANS_SEQ:    next_cnt = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
                TRANS_IDLE:   next_cnt = 5'd0;
                default:      next_cnt = cnt;
            endcase
        end else if (hresp_e'(HRESP) != RESP_OKAY) begin
            // A non-OKAY response ends the burst early.
            next_cnt = 5'd0;
        end
    end

    assign hold   = lock_pad[owner] & req_pad[owner];
    assign arb_ok = HREADY & (next_cnt == 5'd0) & ~hold;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] rr_ptr;

    // Walk the search order backwards so the first requester after rr_ptr is assigned last.
    always_comb begin
        logic [2:0] idx;
        idx    = '0;
        winner = DEF_IDX;
        for (int k = NUM_MST; k >= 1; k--) begin
            idx = 3'((int'(rr_ptr) + k) % NUM_MST);
            if (req_pad[idx]) winner = idx;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)      rr_ptr <= DEF_IDX;
        else if (arb_ok) rr_ptr <= winner;
    end
`else
    always_comb begin
        winner = DEF_IDX;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (req_pad[i]) winner = 3'(i);
        end
    end
`endif

    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (HRESET) begin
            cnt       <= 5'd0;
            owner     <= DEF_IDX;
            HGRANT    <= onehot(DEF_IDX);
            HMASTER   <= DEF_IDX;
            HMASTLOCK <= 1'b0;
        end else begin
            cnt <= next_cnt;
            if (arb_ok) begin
                owner  <= winner;
                HGRANT <= onehot(winner);
            end
            // Address-phase ownership trails the grant by one accepted transfer.
            if (HREADY) begin
                HMASTER   <= owner;
                HMASTLOCK <= lock_pad[owner];
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter (NUM_MST=4, DEF_MST=0): the stimulus queues the expected
// post-edge outputs, and a monitor pops and compares them one cycle later.
`timescale 1ns/1ps
module tb_ahb_bus_arbiter;

    localparam int NUM_MST = 4;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;
    localparam logic [1:0] R_OKAY   = 2'd0;
    localparam logic [1:0] R_ERROR  = 2'd1;

    logic               HCLK = 1'b0;
    logic               HRESET = 1'b1;
    logic [NUM_MST-1:0] HBUSREQ = '0;
    logic [NUM_MST-1:0] HLOCK = '0;
    logic [1:0]         HTRANS = T_IDLE;
    logic [2:0]         HBURST = B_SINGLE;
    logic               HREADY = 1'b1;
    logic [1:0]         HRESP = R_OKAY;
    logic [NUM_MST-1:0] HGRANT;
    logic [2:0]         HMASTER;
    logic               HMASTLOCK;

    always #5 HCLK = ~HCLK;

    ahb_bus_arbiter #(.NUM_MST(NUM_MST), .DEF_MST(0)) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .HBUSREQ(HBUSREQ),
        .HLOCK(HLOCK),
        .HTRANS(HTRANS),
        .HBURST(HBURST),
        .HREADY(HREADY),
        .HRESP(HRESP),
        .HGRANT(HGRANT),
        .HMASTER(HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    typedef struct {
        logic [3:0] grant;
        logic [2:0] master;
        logic       lock;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, required);
        end
    endtask

    // Drive one cycle of bus inputs on the falling edge and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                       input logic [1:0] trans, input logic [2:0] burst, input logic ready,
                       input logic [1:0] resp, input logic [3:0] g, input logic [2:0] m,
                       input logic l, input string name);
        exp_t e;
        @(negedge HCLK);
        HRESET  = rst;
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        HRESP   = resp;
        e.grant  = g;
        e.master = m;
        e.lock   = l;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    // Monitor: compare just after each rising edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".grant"},  32'(HGRANT),    32'(e.grant));
                check({e.name, ".master"}, 32'(HMASTER),   32'(e.master));
                check({e.name, ".lock"},   32'(HMASTLOCK), 32'(e.lock));
                check({e.name, ".onehot"}, 32'($onehot(HGRANT)), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        cyc(1, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, R_OKAY, 4'b0001, 3'd0, 0, "reset0");
        cyc(1, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, R_OKAY, 4'b0001, 3'd0, 0, "reset1");

        // Burst hold: master 2 owns the bus, master 1 waits for the end of an INCR4
        cyc(0, 4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0100, 3'd0, 0, "hold_grant2");
        cyc(0, 4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0100, 3'd2, 0, "hold_own2");
        cyc(0, 4'b0110, 4'b0000, T_NONSEQ, B_INCR4,  1, R_OKAY, 4'b0100, 3'd2, 0, "hold_b1");
        cyc(0, 4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1, R_OKAY, 4'b0100, 3'd2, 0, "hold_b2");
        cyc(0, 4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1, R_OKAY, 4'b0100, 3'd2, 0, "hold_b3");
        cyc(0, 4'b0010, 4'b0000, T_SEQ,    B_INCR4,  1, R_OKAY, 4'b0010, 3'd2, 0, "hold_b4");
        cyc(0, 4'b0010, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0010, 3'd1, 0, "hold_own1");

        // Wait states on beat 2 of master 1's INCR4; master 3 is pending
        cyc(0, 4'b1010, 4'b0000, T_NONSEQ, B_INCR4, 1, R_OKAY, 4'b0010, 3'd1, 0, "ws_b1");
        for (int i = 0; i < 3; i++)
            cyc(0, 4'b1000, 4'b0000, T_SEQ, B_INCR4, 0, R_OKAY, 4'b0010, 3'd1, 0, "ws_stall");
        cyc(0, 4'b1000, 4'b0000, T_SEQ,  B_INCR4,  1, R_OKAY, 4'b0010, 3'd1, 0, "ws_b2");
        cyc(0, 4'b1000, 4'b0000, T_SEQ,  B_INCR4,  1, R_OKAY, 4'b0010, 3'd1, 0, "ws_b3");
        cyc(0, 4'b1000, 4'b0000, T_SEQ,  B_INCR4,  1, R_OKAY, 4'b1000, 3'd1, 0, "ws_b4");
        cyc(0, 4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1, R_OKAY, 4'b1000, 3'd3, 0, "ws_own3");

        // Lock: master 3 holds the bus over SINGLE transfers until it drops HLOCK
        cyc(0, 4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1, R_OKAY, 4'b1000, 3'd3, 1, "lock_s1");
        cyc(0, 4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1, R_OKAY, 4'b1000, 3'd3, 1, "lock_s2");
        cyc(0, 4'b1001, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0001, 3'd3, 0, "lock_rel");
        cyc(0, 4'b0001, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0001, 3'd0, 0, "lock_own0");

        // Error termination of an INCR8 after beat 3; master 2 pending
        cyc(0, 4'b0101, 4'b0000, T_NONSEQ, B_INCR8,  1, R_OKAY,  4'b0001, 3'd0, 0, "err_b1");
        cyc(0, 4'b0101, 4'b0000, T_SEQ,    B_INCR8,  1, R_OKAY,  4'b0001, 3'd0, 0, "err_b2");
        cyc(0, 4'b0101, 4'b0000, T_SEQ,    B_INCR8,  1, R_OKAY,  4'b0001, 3'd0, 0, "err_b3");
        cyc(0, 4'b0100, 4'b0000, T_SEQ,    B_INCR8,  0, R_ERROR, 4'b0001, 3'd0, 0, "err_r1");
        cyc(0, 4'b0100, 4'b0000, T_SEQ,    B_INCR8,  1, R_ERROR, 4'b0100, 3'd0, 0, "err_r2");
        cyc(0, 4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY,  4'b0100, 3'd2, 0, "err_own2");

        // Reset in the middle of a burst returns everything to the default master
        cyc(0, 4'b0100, 4'b0000, T_NONSEQ, B_INCR4,  1, R_OKAY, 4'b0100, 3'd2, 0, "rstmid_b1");
        cyc(1, 4'b0100, 4'b0000, T_SEQ,    B_INCR4,  1, R_OKAY, 4'b0001, 3'd0, 0, "rstmid0");
        cyc(1, 4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1, R_OKAY, 4'b0001, 3'd0, 0, "rstmid1");

        // Policy: all four masters request SINGLE transfers
        for (int i = 0; i < 5; i++) begin
            logic [3:0] g;
            logic [2:0] m;
`ifdef ARB_ROUND_ROBIN_EN
            g = 4'(1 << ((i + 1) % 4));
            m = 3'(i % 4);
`else
            g = 4'b0001;
            m = 3'd0;
`endif
            cyc(0, 4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1, R_OKAY, g, m, 0, "policy");
        end

        cyc(0, 4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1, R_OKAY, 4'b0001, 3'd0, 0, "idle_def");

        repeat (3) @(posedge HCLK);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
